pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary-output dead-time inserter sitting directly downstream of the PWM block. It takes a single PWM waveform (`o_pwm`), resynchronises it into the bus clock domain, and drives a high-side/low-side gate pair with programmable break-before-make gaps. It also provides a sticky fault shutdown. Configuration goes through the same simple register bus used by the other peripherals.

## Interface
- `DT_W`, default 8: width of the dead-time counters and registers.
- `clk_i`  in  1  bus/system clock; the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `re_i`  in  1  register read strobe.
- `we_i`  in  1  register write strobe; a write is `we_i & ~re_i`.
- `addr_i`  in  8  byte address.
- `wdata_i`  in  32  write data.
- `be_i`  in  4  byte enables; a write takes effect only if `be_i[0]=1`.
- `rdata_o`  out  32  combinational read data; unused bits are 0.
- `error_o`  out  1  `(re_i|we_i)` while `addr_i` is not in {0,4,8,12}.
- `i_pwm`  in  1  PWM waveform; may come from a divided clock and is treated as asynchronous.
- `i_fault`  in  1  fault request, synchronous to `clk_i`, active high.
- `o_pwm_h`  out  1  high-side gate.
- `o_pwm_l`  out  1  low-side gate.

## Operation
Registers:
- 0 `ctrl[3:0]`:
  - bit0 enable
  - bit1 output enable
  - bit2 invert H
  - bit3 invert L
- 4 `dt_rise[DT_W-1:0]`: dead cycles on the L-off to H-on transition.
- 8 `dt_fall[DT_W-1:0]`: dead cycles on the H-off to L-on transition.
- 12 `status`:
  - bit0 `fault_sticky`, write-1-to-clear.
  - bit1 `pwm_s`, read-only.
  - bits[4:2] state code, read-only.

Input path: `i_pwm` passes through a 2-flop synchroniser to give `pwm_s`.

FSM states: IDLE(0), LOW_ON(1), DEAD_LH(2), HIGH_ON(3), DEAD_HL(4), FAULT(5).
- IDLE → LOW_ON when enable=1 and `pwm_s`=0. IDLE → DEAD_LH when enable=1 and `pwm_s`=1 (counter loaded with `dt_rise`).
- LOW_ON → DEAD_LH when `pwm_s`=1; the counter loads `dt_rise`.
- DEAD_LH → HIGH_ON when the counter expires. If `pwm_s` returns to 0 before expiry, go to LOW_ON instead.
- HIGH_ON → DEAD_HL when `pwm_s`=0; the counter loads `dt_fall`.
- DEAD_HL → LOW_ON on expiry. If `pwm_s` returns to 1 before expiry, go to HIGH_ON instead.
- Any state → IDLE when enable=0 (next edge).
- Any state → FAULT when `i_fault`=1. Fault has priority over enable and expiry, and sets `fault_sticky`.
- FAULT → IDLE only when `fault_sticky` has been cleared and `i_fault`=0.
- `i_fault`=1 in the same cycle as a W1C write: the set wins.

Dead-time counter:
- The number of dead cycles is `max(dt,1)`, so a value of 0 still gives 1 dead cycle. Overlap is impossible.
- Counter width is DT_W.
- Register writes take effect at the next counter load; a count already in progress is unaffected.

Outputs:
- Raw `h = (state==HIGH_ON)`, raw `l = (state==LOW_ON)`.
- `o_pwm_h = oe ? h^invH : invH`. `o_pwm_l = oe ? l^invL : invL`.
- Both outputs are registered.

## Timing
- Reset: all registers and the state are 0; FSM is in IDLE; `o_pwm_h`=0 and `o_pwm_l`=0.
- A rise of `i_pwm` is visible on `pwm_s` 2 edges later.
- The state changes on the next edge; the raw `l` output drops one edge after `pwm_s` rises.
- `o_pwm_h` rises exactly `max(dt_rise,1)` cycles after `l` drops. The fall direction mirrors this with `dt_fall`.
- Register write: the new value is visible on the edge after the write and is readable in the following cycle.
- Fault: gate outputs reach their inactive levels on the second edge after `i_fault` is sampled high (one edge for the state, one for the output register).
- Reset mid-operation: outputs go to 0 asynchronously; the FSM is in IDLE.

## Structure
- Package `pwm_deadtime_pkg` holds:
  - register address constants
  - the state enum and its encodings
  - ctrl/status bit indices
- Sub-module `sync_2ff`: a generic 2-flop synchroniser, reusable for other async inputs.
- Everything else lives in one module: register file, FSM, counter, output stage.

## Test plan
- **Basic dead time:** `dt_rise`=3, `dt_fall`=5, enable=oe=1, `i_pwm` square wave with 20-cycle period.
  - Expect `l` to fall, then exactly 3 cycles with both outputs low, then `h` high.
  - Expect `h` to fall, then exactly 5 cycles with both low, then `l` high.
  - `o_pwm_h & o_pwm_l` is never 1.
- **Short glitch:** `dt_rise`=6; `i_pwm` high for 2 cycles.
  - Expect `o_pwm_h` to stay 0 and `o_pwm_l` to return to 1.
  - Expect the FSM path LOW_ON → DEAD_LH → LOW_ON.
- **Zero dead time:** `dt_rise`=`dt_fall`=0. Expect exactly 1 dead cycle at each transition.
- **Fault:**
  - Pulse `i_fault` for 1 cycle while in HIGH_ON. Expect both outputs at inactive levels within 2 cycles, `status[0]`=1, and the FSM held in FAULT.
  - Write 1 to `status[0]`. Expect a return to IDLE, then normal operation.
- **Polarity and oe:**
  - invH=1, invL=0, oe=0: expect `o_pwm_h`=1 and `o_pwm_l`=0 constantly.
  - oe=1: expect `o_pwm_h` to be the inverted raw `h`.
- **Bus:**
  - Read addr 16: expect `error_o`=1 and `rdata_o`=0.
  - Write ctrl with `be_i`=0: expect no change.
  - Assert async reset mid-DEAD_HL: expect outputs 0 immediately and state IDLE.

Source files
------------

// File: rtl/pwm_deadtime_pkg.sv
// Shared constants for the complementary dead-time inserter.
// Holds register map, FSM state encodings and ctrl/status bit indices.
package pwm_deadtime_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'd0;
    localparam logic [7:0] ADDR_DT_RISE = 8'd4;
    localparam logic [7:0] ADDR_DT_FALL = 8'd8;
    localparam logic [7:0] ADDR_STATUS  = 8'd12;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_OE    = 1;
    localparam int CTRL_INV_H = 2;
    localparam int CTRL_INV_L = 3;

    localparam int STAT_FAULT = 0;
    localparam int STAT_PWM   = 1;
    localparam int STAT_ST_LO = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOW_ON  = 3'd1,
        ST_DEAD_LH = 3'd2,
        ST_HIGH_ON = 3'd3,
        ST_DEAD_HL = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

endpackage

// File: rtl/pwm_deadtime_sync.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Ports: clk_i, rst_i (async high), d (async in), q (synchronised out).
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with break-before-make dead time and sticky fault.
// Ports: register bus (re/we/addr/wdata/be -> rdata/error), i_pwm, i_fault, o_pwm_h/l.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        error_o,
    input  logic        i_pwm,
    input  logic        i_fault,
    output logic        o_pwm_h,
    output logic        o_pwm_l
);

    logic [3:0]      ctrl;
    logic [DT_W-1:0] dt_rise;
    logic [DT_W-1:0] dt_fall;
    logic            fault_sticky;
    logic            pwm_s;
    state_t          state;
    logic [DT_W-1:0] cnt;

    logic addr_ok;
    logic wr;

    assign addr_ok = (addr_i == ADDR_CTRL) || (addr_i == ADDR_DT_RISE) ||
                     (addr_i == ADDR_DT_FALL) || (addr_i == ADDR_STATUS);
    assign error_o = (re_i | we_i) & ~addr_ok;
    assign wr      = we_i & ~re_i & be_i[0];

    // Counter holds remaining dead cycles minus one; 0 still yields one cycle.
    function automatic logic [DT_W-1:0] dt_load(input logic [DT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    sync_2ff #(.W(1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (i_pwm),
        .q     (pwm_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl         <= '0;
            dt_rise      <= '0;
            dt_fall      <= '0;
            fault_sticky <= 1'b0;
        end else begin
            if (wr && addr_i == ADDR_CTRL)    ctrl    <= wdata_i[3:0];
            if (wr && addr_i == ADDR_DT_RISE) dt_rise <= wdata_i[DT_W-1:0];
            if (wr && addr_i == ADDR_DT_FALL) dt_fall <= wdata_i[DT_W-1:0];
            // A fault arriving together with the clear must not be lost.
            if (i_fault)
                fault_sticky <= 1'b1;
            else if (wr && addr_i == ADDR_STATUS && wdata_i[STAT_FAULT])
                fault_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            o_pwm_h <= 1'b0;
            o_pwm_l <= 1'b0;
        end else begin
            o_pwm_h <= ctrl[CTRL_OE] ?
                       ((state == ST_HIGH_ON) ^ ctrl[CTRL_INV_H]) : ctrl[CTRL_INV_H];
            o_pwm_l <= ctrl[CTRL_OE] ?
                       ((state == ST_LOW_ON) ^ ctrl[CTRL_INV_L]) : ctrl[CTRL_INV_L];
            if (i_fault) begin
                state <= ST_FAULT;
            end else if (state == ST_FAULT) begin
                // Leaving FAULT requires software to acknowledge the sticky flag.
                if (!fault_sticky) state <= ST_IDLE;
            end else if (!ctrl[CTRL_EN]) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE, ST_LOW_ON: begin
                        if (pwm_s) begin
                            state <= ST_DEAD_LH;
                            cnt   <= dt_load(dt_rise);
                        end else begin
                            state <= ST_LOW_ON;
                        end
                    end
                    ST_DEAD_LH: begin
                        if (!pwm_s)          state <= ST_LOW_ON;
                        else if (cnt == '0)  state <= ST_HIGH_ON;
                        else                 cnt   <= cnt - 1'b1;
                    end
                    ST_HIGH_ON: begin
                        if (!pwm_s) begin
                            state <= ST_DEAD_HL;
                            cnt   <= dt_load(dt_fall);
                        end
                    end
                    ST_DEAD_HL: begin
                        if (pwm_s)           state <= ST_HIGH_ON;
                        else if (cnt == '0)  state <= ST_LOW_ON;
                        else                 cnt   <= cnt - 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        if (re_i) begin
            case (addr_i)
                ADDR_CTRL:    rdata_o[3:0]      = ctrl;
                ADDR_DT_RISE: rdata_o[DT_W-1:0] = dt_rise;
                ADDR_DT_FALL: rdata_o[DT_W-1:0] = dt_fall;
                ADDR_STATUS: begin
                    rdata_o[STAT_FAULT]             = fault_sticky;
                    rdata_o[STAT_PWM]               = pwm_s;
                    rdata_o[STAT_ST_LO+2:STAT_ST_LO] = state;
                end
                default: rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed self-checking bench for pwm_deadtime.
// Each task drives one scenario and checks its own results.
module tb_pwm_deadtime;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        re_i = 1'b0;
    logic        we_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] rdata_o;
    logic        error_o;
    logic        i_pwm = 1'b0;
    logic        i_fault = 1'b0;
    logic        o_pwm_h;
    logic        o_pwm_l;

    int checks = 0;
    int failures = 0;

    pwm_deadtime #(.DT_W(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (re_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rdata_o (rdata_o),
        .error_o (error_o),
        .i_pwm   (i_pwm),
        .i_fault (i_fault),
        .o_pwm_h (o_pwm_h),
        .o_pwm_l (o_pwm_l)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        addr_i = a; wdata_i = d; be_i = b; we_i = 1'b1;
        cyc();
        we_i = 1'b0; be_i = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        addr_i = a; re_i = 1'b1;
        #1;
        d = rdata_o;
        re_i = 1'b0;
    endtask

    task automatic rd_state(output int s);
        logic [31:0] d;
        rd(8'd12, d);
        s = int'(d[4:2]);
    endtask

    // Square wave, 20-cycle period; measures gaps, pulse widths, overlap.
    task automatic run_square(input bit ih, input bit il,
                              output int rg, output int fg,
                              output int hl, output int ll, output int ov);
        int gap, hr, lr;
        bit ph, pl, ah, al;
        rg = -1; fg = -1; hl = -1; ll = -1; ov = 0;
        gap = 0; hr = 0; lr = 0; ph = 1'b0; pl = 1'b1;
        for (int k = 0; k < 80; k++) begin
            i_pwm = ((k / 10) % 2 == 0);
            cyc();
            ah = o_pwm_h ^ ih;
            al = o_pwm_l ^ il;
            if (ah && al) ov++;
            if (ah || al) begin
                if (ah && !ph) rg = gap;
                if (al && !pl) fg = gap;
                gap = 0;
            end else begin
                gap++;
            end
            if (ah) hr++;
            else begin
                if (ph) hl = hr;
                hr = 0;
            end
            if (al) lr++;
            else begin
                if (pl) ll = lr;
                lr = 0;
            end
            ph = ah;
            pl = al;
        end
        i_pwm = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        wait_cyc(3);
        if (o_pwm_h !== 1'b0 || o_pwm_l !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%b%b exp=00", o_pwm_h, o_pwm_l);
        end
        checks++;
        for (int a = 0; a < 16; a += 4) begin
            rd(8'(a), d);
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=0", a, d);
            end
            checks++;
        end
        cyc();
        rst_i = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int rg, fg, hl, ll, ov;
        wr(8'd4, 32'd3, 4'h1);
        wr(8'd8, 32'd5, 4'h1);
        wr(8'd0, 32'h3, 4'h1);
        i_pwm = 1'b0;
        wait_cyc(8);
        run_square(1'b0, 1'b0, rg, fg, hl, ll, ov);
        if (rg !== 3) begin failures++; $display("FAIL basic_rise_gap got=%0d exp=3", rg); end
        checks++;
        if (fg !== 5) begin failures++; $display("FAIL basic_fall_gap got=%0d exp=5", fg); end
        checks++;
        if (hl !== 7) begin failures++; $display("FAIL basic_h_width got=%0d exp=7", hl); end
        checks++;
        if (ll !== 5) begin failures++; $display("FAIL basic_l_width got=%0d exp=5", ll); end
        checks++;
        if (ov !== 0) begin failures++; $display("FAIL basic_overlap got=%0d exp=0", ov); end
        checks++;
    endtask

    task automatic test_glitch();
        int s;
        bit saw_dead, saw_high, h_seen;
        wr(8'd4, 32'd6, 4'h1);
        i_pwm = 1'b0;
        wait_cyc(8);
        saw_dead = 0; saw_high = 0; h_seen = 0;
        i_pwm = 1'b1;
        cyc();
        cyc();
        i_pwm = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            rd_state(s);
            if (s == 2) saw_dead = 1;
            if (s == 3) saw_high = 1;
            if (o_pwm_h) h_seen = 1;
        end
        if (saw_dead !== 1'b1 || saw_high !== 1'b0) begin
            failures++;
            $display("FAIL glitch_path got dead=%b high=%b exp dead=1 high=0", saw_dead, saw_high);
        end
        checks++;
        rd_state(s);
        if (s !== 1) begin failures++; $display("FAIL glitch_state got=%0d exp=1", s); end
        checks++;
        if (h_seen !== 1'b0 || o_pwm_l !== 1'b1) begin
            failures++;
            $display("FAIL glitch_out got h=%b l=%b exp h=0 l=1", h_seen, o_pwm_l);
        end
        checks++;
    endtask

    task automatic test_zero_dt();
        int rg, fg, hl, ll, ov;
        wr(8'd4, 32'd0, 4'h1);
        wr(8'd8, 32'd0, 4'h1);
        i_pwm = 1'b0;
        wait_cyc(8);
        run_square(1'b0, 1'b0, rg, fg, hl, ll, ov);
        if (rg !== 1 || fg !== 1) begin
            failures++;
            $display("FAIL zero_gap got rise=%0d fall=%0d exp 1 1", rg, fg);
        end
        checks++;
        if (hl !== 9 || ll !== 9 || ov !== 0) begin
            failures++;
            $display("FAIL zero_width got h=%0d l=%0d ov=%0d exp 9 9 0", hl, ll, ov);
        end
        checks++;
    endtask

    task automatic test_fault();
        int s;
        logic [31:0] d;
        wr(8'd4, 32'd3, 4'h1);
        wr(8'd8, 32'd5, 4'h1);
        i_pwm = 1'b1;
        wait_cyc(12);
        rd_state(s);
        if (s !== 3) begin failures++; $display("FAIL fault_pre_state got=%0d exp=3", s); end
        checks++;
        i_fault = 1'b1;
        cyc();
        i_fault = 1'b0;
        if (o_pwm_h !== 1'b1) begin failures++; $display("FAIL fault_edge1 got=%b exp=1", o_pwm_h); end
        checks++;
        cyc();
        if (o_pwm_h !== 1'b0 || o_pwm_l !== 1'b0) begin
            failures++;
            $display("FAIL fault_out got=%b%b exp=00", o_pwm_h, o_pwm_l);
        end
        checks++;
        wait_cyc(5);
        rd(8'd12, d);
        if (d[0] !== 1'b1 || d[4:2] !== 3'd5) begin
            failures++;
            $display("FAIL fault_status got=%h exp sticky=1 state=5", d);
        end
        checks++;
        i_fault = 1'b1;
        wr(8'd12, 32'h1, 4'h1);
        i_fault = 1'b0;
        rd(8'd12, d);
        if (d[0] !== 1'b1) begin failures++; $display("FAIL fault_set_wins got=%b exp=1", d[0]); end
        checks++;
        wr(8'd12, 32'h1, 4'h1);
        rd(8'd12, d);
        if (d[0] !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", d[0]); end
        checks++;
        cyc();
        rd_state(s);
        if (s !== 0) begin failures++; $display("FAIL fault_to_idle got=%0d exp=0", s); end
        checks++;
        wait_cyc(8);
        if (o_pwm_h !== 1'b1 || o_pwm_l !== 1'b0) begin
            failures++;
            $display("FAIL fault_resume got=%b%b exp=10", o_pwm_h, o_pwm_l);
        end
        checks++;
        i_pwm = 1'b0;
    endtask

    task automatic test_polarity();
        int bad, rg, fg, hl, ll, ov;
        wr(8'd0, 32'h5, 4'h1);
        wait_cyc(3);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            i_pwm = ((k / 10) % 2 == 0);
            cyc();
            if (o_pwm_h !== 1'b1 || o_pwm_l !== 1'b0) bad++;
        end
        if (bad !== 0) begin failures++; $display("FAIL pol_oe0 got bad=%0d exp=0", bad); end
        checks++;
        wr(8'd0, 32'h7, 4'h1);
        i_pwm = 1'b0;
        wait_cyc(8);
        run_square(1'b1, 1'b0, rg, fg, hl, ll, ov);
        if (rg !== 3 || fg !== 5 || hl !== 7 || ov !== 0) begin
            failures++;
            $display("FAIL pol_invh got rise=%0d fall=%0d h=%0d ov=%0d exp 3 5 7 0",
                     rg, fg, hl, ov);
        end
        checks++;
    endtask

    task automatic test_bus();
        logic [31:0] d;
        addr_i = 8'd16; re_i = 1'b1;
        #1;
        if (error_o !== 1'b1 || rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL bus_bad_addr got err=%b data=%h exp 1 0", error_o, rdata_o);
        end
        checks++;
        addr_i = 8'd8;
        #1;
        if (error_o !== 1'b0) begin failures++; $display("FAIL bus_good_addr got=%b exp=0", error_o); end
        checks++;
        re_i = 1'b0;
        wr(8'd0, 32'h0, 4'h0);
        rd(8'd0, d);
        if (d !== 32'h7) begin failures++; $display("FAIL bus_be0 got=%h exp=7", d); end
        checks++;
        wr(8'd4, 32'hFFFF_FF5A, 4'h1);
        rd(8'd4, d);
        if (d !== 32'h5A) begin failures++; $display("FAIL bus_dt_rd got=%h exp=5a", d); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int s;
        wr(8'd4, 32'd1, 4'h1);
        wr(8'd8, 32'd200, 4'h1);
        wr(8'd0, 32'hF, 4'h1);
        i_pwm = 1'b1;
        wait_cyc(10);
        i_pwm = 1'b0;
        wait_cyc(6);
        rd_state(s);
        if (s !== 4 || o_pwm_h !== 1'b1 || o_pwm_l !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got state=%0d out=%b%b exp 4 11", s, o_pwm_h, o_pwm_l);
        end
        checks++;
        #2;
        rst_i = 1'b1;
        #1;
        if (o_pwm_h !== 1'b0 || o_pwm_l !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_out got=%b%b exp=00", o_pwm_h, o_pwm_l);
        end
        checks++;
        rd_state(s);
        if (s !== 0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", s); end
        checks++;
        cyc();
        rst_i = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_zero_dt();
        test_fault();
        test_polarity();
        test_bus();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
